instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the PC, drives the byte address to the

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               pred_taken;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO with flush; accepts push+pop while full.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  if_entry_t wdata_i,
  output if_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(DEPTH);

  if_entry_t       mem_q [DEPTH];
  logic [PW:0]     wptr_q, wptr_d;
  logic [PW:0]     rptr_q, rptr_d;
  logic            push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // Pointer wrap bit distinguishes full from empty; a pop frees the slot the push reuses.
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign push_en = push_i && !flush_i && (!full_o || pop_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + 1'b1;
      if (pop_en)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[PW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC ownership, imem access, fetch buffer, redirects and fault flag.
// Optional backward-taken branch prediction enabled by defining IF_BTFN_PREDICT_EN.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 64,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic        pred_taken
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              push, pop, flush, full, empty;
  logic              pc_bad, tgt_bad;
  logic [ADDR_W-1:0] seq_next;
  logic              pred;
  if_entry_t         entry_in, head;

  assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_LIMIT);
  assign tgt_bad = (redirect_target[1:0] != 2'b00) || (redirect_target >= MEM_LIMIT);

`ifdef IF_BTFN_PREDICT_EN
  logic [5:0]  opcode;
  logic [15:0] imm;
  assign opcode   = imem_data[31:26];
  assign imm      = imem_data[15:0];
  // Backward conditional branches are predicted taken, everything else falls through.
  assign pred     = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && imm[15];
  assign seq_next = pred ? (pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00}) : (pc_q + 32'd4);
`else
  assign pred     = 1'b0;
  assign seq_next = pc_q + 32'd4;
`endif

  assign pop      = instr_valid && instr_ready;
  assign entry_in = '{pc: pc_q, instr: imem_data, pred_taken: pred};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_target;
      if (state_q == HALT) begin
        if (!tgt_bad) begin
          state_d = FETCH;
          fault_d = 1'b0;
        end
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: begin
          if (pc_bad) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = seq_next;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (entry_in),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign fetch_fault = fault_q;

`ifdef IF_BTFN_PREDICT_EN
  assign pred_taken = !empty && head.pred_taken;
`else
  logic unused_pred;
  assign unused_pred = head.pred_taken;
  assign pred_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a stream-level reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_fault;
  logic        pred_taken;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .pred_taken      (pred_taken)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int b;
    b = int'(a[5:0]);
    return {mem[b], mem[(b + 1) % 64], mem[(b + 2) % 64], mem[(b + 3) % 64]};
  endfunction

  assign imem_data = rd_word(imem_addr);

  // Reference: what the instruction at pc predicts, and where the stream goes next.
  function automatic logic exp_pred(input logic [31:0] pc);
    logic [31:0] w;
    w = rd_word(pc);
`ifdef IF_BTFN_PREDICT_EN
    return ((w[31:26] == 6'd4) || (w[31:26] == 6'd5)) && w[15];
`else
    return (w == 32'h0) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] pc);
    logic [31:0] w;
    logic signed [31:0] off;
    w   = rd_word(pc);
    off = 32'(signed'(w[15:0])) * 4;
    if (exp_pred(pc)) return pc + 32'd4 + 32'(off);
    return pc + 32'd4;
  endfunction

  task automatic load_mem();
    logic [31:0] words [0:15];
    words[0] = 32'h3C020003; words[1] = 32'h00421820; words[2] = 32'hAC030004;
    words[3] = 32'h1042FFFC; words[4] = 32'h00422004; words[5] = 32'h8C050004;
    for (int i = 6; i < 16; i++) words[i] = $urandom() & 32'h03FF_FFFF;
    for (int i = 0; i < 16; i++) begin
      mem[4*i]     = words[i][31:24];
      mem[4*i + 1] = words[i][23:16];
      mem[4*i + 2] = words[i][15:8];
      mem[4*i + 3] = words[i][7:0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", pred_taken); end
    reset = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_valid: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_cycle_addr: got %h expected 00000000", imem_addr); end
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h3C020003}) begin
      errors++; $display("FAIL first_instr: got v=%b pc=%h i=%h expected v=1 pc=00000000 i=3c020003", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h3C020003}) begin
          errors++; $display("FAIL stall_head_c%0d: got v=%b pc=%h i=%h expected v=1 pc=00000000 i=3c020003", c, instr_valid, instr_pc, instr);
        end
      end
    end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h expected 00000008", imem_addr); end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * i), rd_word(32'(4 * i))}) begin
        errors++; $display("FAIL stall_drain_%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", i, instr_valid, instr_pc, instr, 32'(4 * i), rd_word(32'(4 * i)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_prefill: got %b expected 1", instr_valid); end
    redirect_valid = 1'b1;
    redirect_target = 32'h10;
    instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid %b expected 0", instr_valid); end
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h10, 32'h00422004}) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h expected v=1 pc=00000010 i=00422004", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_fault();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL misalign_fault: got %b expected 1", fetch_fault); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_valid: got %b expected 0", instr_valid); end
    repeat (2) @(negedge clk);
    checks++; if ({fetch_fault, imem_addr} !== {1'b1, 32'h6}) begin errors++; $display("FAIL halt_sticky: got f=%b a=%h expected f=1 a=00000006", fetch_fault, imem_addr); end
    redirect_valid = 1'b1;
    redirect_target = 32'h44;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if ({fetch_fault, instr_valid} !== 2'b10) begin errors++; $display("FAIL halt_bad_redir: got f=%b v=%b expected f=1 v=0", fetch_fault, instr_valid); end
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", fetch_fault); end
    @(negedge clk);
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL resume: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic [31:0] start;
    bit done;
`ifdef IF_BTFN_PREDICT_EN
    start = 32'h10;
`else
    start = 32'h0;
`endif
    done = 1'b0;
    last_pc = 32'hFFFF_FFFF;
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = start;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = start;
    for (int i = 0; i < 300 && !done; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if (instr_valid && instr_ready) begin
        checks++;
        if ({instr_pc, instr, pred_taken} !== {exp_pc, rd_word(exp_pc), exp_pred(exp_pc)}) begin
          errors++; $display("FAIL free_run_stream: got pc=%h i=%h p=%b expected pc=%h i=%h p=%b", instr_pc, instr, pred_taken, exp_pc, rd_word(exp_pc), exp_pred(exp_pc));
        end
        last_pc = instr_pc;
        exp_pc = exp_next(exp_pc);
      end else if (fetch_fault && !instr_valid) begin
        done = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL free_run_fault: got %b expected 1", fetch_fault); end
    checks++; if (last_pc !== 32'h3C) begin errors++; $display("FAIL free_run_last: got %h expected 0000003c", last_pc); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL free_run_addr: got %h expected 00000040", imem_addr); end
  endtask

  task automatic test_predict();
    logic [31:0] exp_second;
    bit got;
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hC;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IF_BTFN_PREDICT_EN
    exp_second = 32'h0;
`else
    exp_second = 32'h10;
`endif
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (instr_valid) got = 1'b1; else @(negedge clk);
    end
    checks++;
    if ({got, instr_pc, instr, pred_taken} !== {1'b1, 32'hC, 32'h1042FFFC, exp_pred(32'hC)}) begin
      errors++; $display("FAIL predict_branch: got v=%b pc=%h i=%h p=%b expected v=1 pc=0000000c i=1042fffc p=%b", got, instr_pc, instr, pred_taken, exp_pred(32'hC));
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, pred_taken} !== {1'b1, exp_second, 1'b0}) begin
      errors++; $display("FAIL predict_next: got v=%b pc=%h p=%b expected v=1 pc=%h p=0", instr_valid, instr_pc, pred_taken, exp_second);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %b expected 1", instr_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({instr_valid, imem_addr, fetch_fault} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL mid_reset: got v=%b a=%h f=%b expected v=0 a=00000000 f=0", instr_valid, imem_addr, fetch_fault);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_pc, prev_instr;
    bit hold;
    int deliv;
    do_reset();
    exp_pc = 32'h0;
    hold = 1'b0;
    deliv = 0;
    prev_pc = 32'h0;
    prev_instr = 32'h0;
    for (int i = 0; i < 500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) redirect_target = $urandom() & 32'h7F;
      else redirect_target = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if (instr_valid && hold) begin
        checks++;
        if ({instr_pc, instr} !== {prev_pc, prev_instr}) begin
          errors++; $display("FAIL rand_stable: got pc=%h i=%h expected pc=%h i=%h", instr_pc, instr, prev_pc, prev_instr);
        end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if ({instr_pc, instr, pred_taken} !== {exp_pc, rd_word(exp_pc), exp_pred(exp_pc)}) begin
          errors++; $display("FAIL rand_stream: got pc=%h i=%h p=%b expected pc=%h i=%h p=%b", instr_pc, instr, pred_taken, exp_pc, rd_word(exp_pc), exp_pred(exp_pc));
        end
        exp_pc = exp_next(exp_pc);
        deliv++;
      end
      if (redirect_valid) exp_pc = redirect_target;
      hold = instr_valid && !instr_ready && !redirect_valid;
      prev_pc = instr_pc;
      prev_instr = instr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    checks++; if (deliv < 20) begin errors++; $display("FAIL rand_progress: got %0d deliveries expected at least 20", deliv); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    load_mem();
    test_reset();
    test_stall();
    test_redirect();
    test_fault();
    test_free_run();
    test_predict();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
